// File: rtl/round_pkg.sv
// round_pkg: shared types and constants for the round sequencer.
//   rs_state_t        - sequencer FSM state encoding
//   PH_*              - phase index names within one AES (inverse) round
//   MAX_ROUNDS_AES128 - terminal round index for AES-128 (rounds 0..10)
package round_pkg;

    typedef enum logic [1:0] {RS_IDLE, RS_RUN, RS_DONE} rs_state_t;

    localparam int PH_SHIFT  = 0;
    localparam int PH_SUB    = 1;
    localparam int PH_ADDKEY = 2;
    localparam int PH_MIX    = 3;

    localparam int MAX_ROUNDS_AES128 = 10;

endpackage

// File: rtl/round_sequencer_phase_counter.sv
// phase_counter: sub-step counter within one round.
//   CLK   in  clock
//   RESET in  synchronous active-high reset
//   clr   in  force phase to the first phase
//   en    in  advance one phase
//   short in  round ends one phase early (last phase = PHASES-2)
//   phase out current phase
//   wrap  out en while phase is at the effective last phase (combinational)
// On wrap the phase holds; the owner clears it with clr when another round follows.
module phase_counter
    import round_pkg::*;
#(
    parameter int PHASES = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        clr,
    input  logic                        en,
    input  logic                        short,
    output logic [$clog2(PHASES)-1:0]   phase,
    output logic                        wrap
);

    localparam int PW = $clog2(PHASES);

    logic [PW-1:0] phase_q, phase_d, last;

    always_comb begin
        last    = short ? PW'(PHASES - 2) : PW'(PHASES - 1);
        wrap    = en && (phase_q == last);
        phase_d = clr ? PW'(PH_SHIFT) : (en && !wrap) ? phase_q + 1'b1 : phase_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) phase_q <= '0;
        else       phase_q <= phase_d;
    end

    assign phase = phase_q;

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: sequences M+1 rounds of PHASES sub-steps, counting up or down.
//   CLK         in  clock
//   RESET       in  synchronous active-high reset
//   start       in  begin a sequence (IDLE only)
//   dir         in  0 = count 0..M, 1 = count M..0 (latched at start)
//   max_count   in  terminal round M, 0 selects MAX_DEFAULT (latched at start)
//   step        in  advance one phase (RUN only)
//   count_out   out current round index
//   phase_out   out current phase within the round
//   busy        out high in RUN
//   first_round out busy and at the starting round
//   last_round  out busy and at the terminal round
//   done        out one-cycle pulse after the final phase
// Build option: ROUND_LAST_SKIP_EN drops the last phase of the terminal round.
module round_sequencer
    import round_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int PHASES      = 4,
    parameter int MAX_DEFAULT = MAX_ROUNDS_AES128
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        start,
    input  logic                        dir,
    input  logic [WIDTH-1:0]            max_count,
    input  logic                        step,
    output logic [WIDTH-1:0]            count_out,
    output logic [$clog2(PHASES)-1:0]   phase_out,
    output logic                        busy,
    output logic                        first_round,
    output logic                        last_round,
    output logic                        done
);

    rs_state_t        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, max_q, max_d, m_sel;
    logic             dir_q, dir_d;
    logic             start_acc, adv_en, terminal, short_last, wrap;

    assign start_acc = (state_q == RS_IDLE) && start;
    assign adv_en    = (state_q == RS_RUN) && step;
    assign terminal  = dir_q ? (count_q == '0) : (count_q == max_q);
    assign m_sel     = (max_count == '0) ? WIDTH'(MAX_DEFAULT) : max_count;

`ifdef ROUND_LAST_SKIP_EN
    assign short_last = terminal;
`else
    assign short_last = 1'b0;
`endif

    // Phase is cleared on entry and on every non-final round boundary;
    // on the final wrap it holds so the last phase stays visible.
    phase_counter #(.PHASES(PHASES)) u_phase (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (start_acc || (wrap && !terminal)),
        .en    (adv_en),
        .short (short_last),
        .phase (phase_out),
        .wrap  (wrap)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RS_IDLE;
            count_q <= '0;
            max_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            dir_q   <= dir_d;
        end
    end

    // Terminal check gates the count update, so no wrap-around can occur.
    always_comb begin
        state_d = (state_q == RS_IDLE) ? (start ? RS_RUN : RS_IDLE) :
                  (state_q == RS_RUN)  ? ((wrap && terminal) ? RS_DONE : RS_RUN) :
                                         RS_IDLE;
        dir_d   = start_acc ? dir : dir_q;
        max_d   = start_acc ? m_sel : max_q;
        count_d = start_acc           ? (dir ? m_sel : '0) :
                  (wrap && !terminal) ? (dir_q ? count_q - 1'b1 : count_q + 1'b1) :
                                        count_q;
    end

    always_comb begin
        busy        = (state_q == RS_RUN);
        done        = (state_q == RS_DONE);
        first_round = busy && (count_q == (dir_q ? max_q : '0));
        last_round  = busy && terminal;
        count_out   = count_q;
    end

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed, table-driven check of round_sequencer against a behavioural model.
module tb_round_sequencer;

    localparam int W = 5;
    localparam int P = 4;
`ifdef ROUND_LAST_SKIP_EN
    localparam int SKIP = 1;
`else
    localparam int SKIP = 0;
`endif

    logic         CLK = 1'b0;
    logic         RESET, start, dir, step;
    logic [W-1:0] max_count, count_out;
    logic [1:0]   phase_out;
    logic         busy, first_round, last_round, done;

    always #5 CLK = ~CLK;

    round_sequencer #(.WIDTH(W), .PHASES(P), .MAX_DEFAULT(10)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .dir(dir), .max_count(max_count),
        .step(step), .count_out(count_out), .phase_out(phase_out), .busy(busy),
        .first_round(first_round), .last_round(last_round), .done(done)
    );

    int total = 0;
    int bad   = 0;

    // model: ms 0 idle, 1 run, 2 done
    int ms, mc, mp, md, mm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit st, input bit sp);
        int lp;
        bit term;
        if (ms == 0) begin
            if (st) begin
                md = int'(dir);
                mm = (max_count == 0) ? 10 : int'(max_count);
                mc = (md != 0) ? mm : 0;
                mp = 0;
                ms = 1;
            end
        end else if (ms == 1) begin
            if (sp) begin
                term = (md != 0) ? (mc == 0) : (mc == mm);
                lp   = term ? P - 1 - SKIP : P - 1;
                if (mp < lp) mp++;
                else if (!term) begin
                    mp = 0;
                    mc = (md != 0) ? mc - 1 : mc + 1;
                end else ms = 2;
            end
        end else ms = 0;
    endtask

    task automatic check_outs();
        chk("busy", busy, ms == 1);
        chk("done", done, ms == 2);
        chk("count", count_out, mc);
        chk("phase", phase_out, mp);
        chk("first_round", first_round, ms == 1 && mc == ((md != 0) ? mm : 0));
        chk("last_round", last_round, ms == 1 && mc == ((md != 0) ? 0 : mm));
    endtask

    // inputs change at negedge; the following posedge consumes them
    task automatic cyc(input bit st, input bit sp);
        start = st;
        step  = sp;
        model_edge(st, sp);
        @(negedge CLK);
        check_outs();
    endtask

    task automatic do_reset();
        RESET = 1'b1; start = 1'b0; step = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        ms = 0; mc = 0; mp = 0; md = 0; mm = 0;
        check_outs();
    endtask

    // runs from the first RUN cycle to the done pulse; n = accepted steps
    task automatic run(input bit spam, input bit rnd, output int n, output int dones);
        bit sp;
        n = 0;
        dones = 0;
        for (int i = 0; i < 600; i++) begin
            if (done) break;
            sp = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy && sp) n++;
            cyc(spam, sp);
        end
        chk("done_seen", done, 1);
        dones = done ? 1 : 0;
        cyc(spam, 1'b1);
        if (done) dones++;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0);
            if (done) dones++;
        end
    endtask

    typedef struct {
        bit           d;
        logic [W-1:0] mcnt;
        bit           spam;
        bit           sws;
        int           steps;
        int           first_cnt;
        int           last_cnt;
    } vec_t;

    vec_t vt[4];
    int   n, dones;

    initial begin
        vt[0] = '{d: 1'b0, mcnt: 5'd0,  spam: 1'b0, sws: 1'b0, steps: 44 - SKIP,  first_cnt: 0,  last_cnt: 10};
        vt[1] = '{d: 1'b1, mcnt: 5'd3,  spam: 1'b1, sws: 1'b0, steps: 16 - SKIP,  first_cnt: 3,  last_cnt: 0};
        vt[2] = '{d: 1'b0, mcnt: 5'd1,  spam: 1'b0, sws: 1'b1, steps: 8 - SKIP,   first_cnt: 0,  last_cnt: 1};
        vt[3] = '{d: 1'b1, mcnt: 5'd31, spam: 1'b1, sws: 1'b1, steps: 128 - SKIP, first_cnt: 31, last_cnt: 0};
        RESET = 1'b1; start = 1'b0; step = 1'b0; dir = 1'b0; max_count = '0;
        @(negedge CLK);
        do_reset();
        chk("reset_count", count_out, 0);
        chk("reset_busy", busy, 0);

        foreach (vt[k]) begin
            do_reset();
            dir       = vt[k].d;
            max_count = vt[k].mcnt;
            cyc(1'b1, vt[k].sws);
            chk("entry_count", count_out, vt[k].first_cnt);
            chk("entry_phase", phase_out, 0);
            chk("entry_first", first_round, 1);
            run(vt[k].spam, 1'b0, n, dones);
            chk("steps", n, vt[k].steps);
            chk("done_pulses", dones, 1);
            chk("idle_hold", count_out, vt[k].last_cnt);
            chk("idle_busy", busy, 0);
        end

        // random step gating, start together with step in IDLE
        do_reset();
        dir = 1'b0; max_count = 5'd2;
        cyc(1'b1, 1'b1);
        chk("rnd_entry_phase", phase_out, 0);
        run(1'b0, 1'b1, n, dones);
        chk("rnd_steps", n, 12 - SKIP);
        chk("rnd_dones", dones, 1);

        // reset mid-run at count 5, phase 2
        do_reset();
        dir = 1'b0; max_count = '0;
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 100 && !(count_out == 5 && phase_out == 2); i++) cyc(1'b0, 1'b1);
        chk("mid_count", count_out, 5);
        chk("mid_phase", phase_out, 2);
        RESET = 1'b1; start = 1'b1; step = 1'b1;
        @(negedge CLK);
        ms = 0; mc = 0; mp = 0; md = 0; mm = 0;
        chk("rst_count", count_out, 0);
        chk("rst_phase", phase_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_first", first_round, 0);
        chk("rst_last", last_round, 0);
        RESET = 1'b0;
        cyc(1'b0, 1'b0);
        max_count = 5'd1;
        cyc(1'b1, 1'b0);
        run(1'b0, 1'b0, n, dones);
        chk("post_rst_steps", n, 8 - SKIP);
        chk("post_rst_dones", dones, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
